// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_pkg
// Purpose  : Shared constants and helpers for the pipeline hazard scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

    localparam int TW_DEFAULT       = 2;
    localparam int MULT_LAT_DEFAULT = 5;
    localparam int DIV_LAT_DEFAULT  = 10;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_W  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_E  = 2'd3;

    // Entry index 0 is the youngest in-flight instruction.
    localparam int STAGE_E = 0;
    localparam int STAGE_M = 1;
    localparam int STAGE_W = 2;
    localparam int NSTAGE  = 3;

    function automatic logic [1:0] stage_fwd_code(input int stage);
        logic [1:0] code;
        case (stage)
            STAGE_E: code = FWD_E;
            STAGE_M: code = FWD_M;
            STAGE_W: code = FWD_W;
            default: code = FWD_RF;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_md_busy_counter.sv
`default_nettype none
// ============================================================================
// Module   : md_busy_counter
// Purpose  : HI/LO unit busy tracker; loads the mult/div latency on start.
// Revision : 1.0 - initial release
// ============================================================================
module md_busy_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int c_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int c_CW  = $clog2(c_MAX + 1);

    logic [c_CW-1:0] r_cnt;

    // A start always reloads, even if a previous operation is still counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= is_div ? c_CW'(DIV_LAT) : c_CW'(MULT_LAT);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CW'(1);
        end
    end

    assign busy = (r_cnt != '0) | start;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Tnew/Tuse hazard unit: stall and per-source forward selects.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSRC     = 2,
    parameter int AW       = 5,
    parameter int TW       = TW_DEFAULT,
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC*AW-1:0]   d_src,
    input  logic [NSRC*TW-1:0]   d_tuse,
    input  logic [AW-1:0]        d_dst,
    input  logic [TW-1:0]        d_tnew,
    input  logic                 d_is_md,
    input  logic                 e_md_start,
    input  logic                 e_md_div,
    input  logic                 flush,
    output logic                 stall,
    output logic [NSRC*2-1:0]    fwd_sel,
    output logic                 md_busy
);

    logic [AW-1:0]   r_dst  [NSTAGE];
    logic [TW-1:0]   r_tnew [NSTAGE];
    logic [NSRC-1:0] w_src_stall;
    logic            w_md_busy;
    logic            w_stall;

    function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        logic [AW-1:0] w_src;
        logic [TW-1:0] w_tuse;
        logic          w_stl;
        logic [1:0]    w_fwd;

        assign w_src  = d_src[gi*AW +: AW];
        assign w_tuse = d_tuse[gi*TW +: TW];

        // Walk oldest to youngest so the youngest matching writer wins.
        always_comb begin
            w_stl = 1'b0;
            w_fwd = FWD_RF;
            for (int s = NSTAGE - 1; s >= 0; s--) begin
                if ((w_src != '0) && (w_src == r_dst[s])) begin
                    w_stl = (r_tnew[s] > w_tuse);
                    w_fwd = (r_tnew[s] == '0) ? stage_fwd_code(s) : FWD_RF;
                end
            end
        end

        assign w_src_stall[gi]   = w_stl;
        assign fwd_sel[gi*2 +: 2] = w_fwd;
    end

    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (e_md_start),
        .is_div (e_md_div),
        .busy   (w_md_busy)
    );

    assign w_stall = (|w_src_stall) | (d_is_md & w_md_busy);
    assign stall   = w_stall;
    assign md_busy = w_md_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSTAGE; s++) begin
                r_dst[s]  <= '0;
                r_tnew[s] <= '0;
            end
        end else begin
            r_dst[STAGE_W]  <= r_dst[STAGE_M];
            r_tnew[STAGE_W] <= tnew_dec(r_tnew[STAGE_M]);
            r_dst[STAGE_M]  <= r_dst[STAGE_E];
            r_tnew[STAGE_M] <= tnew_dec(r_tnew[STAGE_E]);
            // Stall and flush both inject a single bubble into E.
            if (w_stall || flush) begin
                r_dst[STAGE_E]  <= '0;
                r_tnew[STAGE_E] <= '0;
            end else begin
                r_dst[STAGE_E]  <= d_dst;
                r_tnew[STAGE_E] <= d_tnew;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed self-checking bench for hazard_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [9:0]  d_src;
    logic [3:0]  d_tuse;
    logic [4:0]  d_dst;
    logic [1:0]  d_tnew;
    logic        d_is_md;
    logic        e_md_start;
    logic        e_md_div;
    logic        flush;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic        md_busy;

    int n_cmp = 0;
    int n_err = 0;

    hazard_scoreboard dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_src      (d_src),
        .d_tuse     (d_tuse),
        .d_dst      (d_dst),
        .d_tnew     (d_tnew),
        .d_is_md    (d_is_md),
        .e_md_start (e_md_start),
        .e_md_div   (e_md_div),
        .flush      (flush),
        .stall      (stall),
        .fwd_sel    (fwd_sel),
        .md_busy    (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_d(input logic [4:0] s1, input logic [4:0] s0,
                         input logic [1:0] u1, input logic [1:0] u0,
                         input logic [4:0] dst, input logic [1:0] tnew);
        d_src  = {s1, s0};
        d_tuse = {u1, u0};
        d_dst  = dst;
        d_tnew = tnew;
        #1;
    endtask

    task automatic idle();
        d_is_md = 1'b0; e_md_start = 1'b0; e_md_div = 1'b0; flush = 1'b0;
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        e_md_start = 1'b0; e_md_div = 1'b0; flush = 1'b0;
        d_src   = 10'($urandom);
        d_tuse  = 4'($urandom);
        d_dst   = 5'($urandom_range(1, 31));
        d_tnew  = 2'($urandom);
        d_is_md = 1'b1;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fwd", 32'(fwd_sel), 32'd0);
        chk("rst_busy", 32'(md_busy), 32'd0);
        tick(); tick();
        chk("rst_hold_stall", 32'(stall), 32'd0);
        chk("rst_hold_fwd", 32'(fwd_sel), 32'd0);
        idle();
        rst_n = 1'b1;
        tick();

        // ALU producer $3 followed by a consumer with tuse=1
        set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 2'd1);
        tick();
        set_d(5'd0, 5'd3, 2'd0, 2'd1, 5'd0, 2'd0);
        chk("alu_e_stall", 32'(stall), 32'd0);
        chk("alu_e_fwd", 32'(fwd_sel), 32'h0);
        tick();
        chk("alu_m_stall", 32'(stall), 32'd0);
        chk("alu_m_fwd", 32'(fwd_sel), 32'h2);
        tick();
        chk("alu_w_fwd", 32'(fwd_sel), 32'h1);
        idle(); tick(); tick(); tick();
        chk("drain_fwd", 32'(fwd_sel), 32'h0);

        // Load $5 followed by a branch reading it in D
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd5, 2'd2);
        tick();
        set_d(5'd6, 5'd5, 2'd0, 2'd0, 5'd0, 2'd0);
        chk("lw_stall1", 32'(stall), 32'd1);
        chk("lw_fwd1", 32'(fwd_sel), 32'h0);
        tick();
        chk("lw_stall2", 32'(stall), 32'd1);
        tick();
        chk("lw_stall3", 32'(stall), 32'd0);
        chk("lw_fwd_w", 32'(fwd_sel), 32'h1);
        idle(); tick(); tick(); tick();

        // $0 writer and reader never interact
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd2);
        tick();
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
        chk("zero_stall", 32'(stall), 32'd0);
        chk("zero_fwd", 32'(fwd_sel), 32'h0);

        // Two writers of $4: youngest (E, tnew 0) wins over M
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd4, 2'd1);
        tick();
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd4, 2'd0);
        tick();
        set_d(5'd4, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
        chk("dbl_stall", 32'(stall), 32'd0);
        chk("dbl_fwd_e", 32'(fwd_sel), 32'hC);
        idle(); tick(); tick(); tick();

        // Younger pending writer blocks the ready older one
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd4, 2'd0);
        tick();
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd4, 2'd2);
        tick();
        set_d(5'd0, 5'd4, 2'd0, 2'd0, 5'd0, 2'd0);
        chk("pend_stall", 32'(stall), 32'd1);
        chk("pend_fwd", 32'(fwd_sel), 32'h0);
        set_d(5'd0, 5'd4, 2'd0, 2'd2, 5'd0, 2'd0);
        chk("pend_tuse_stall", 32'(stall), 32'd0);
        chk("pend_tuse_fwd", 32'(fwd_sel), 32'h0);
        idle(); tick(); tick(); tick();

        // div start followed by mflo
        e_md_start = 1'b1; e_md_div = 1'b1; d_is_md = 1'b1;
        #1;
        chk("div_start_busy", 32'(md_busy), 32'd1);
        chk("div_start_stall", 32'(stall), 32'd1);
        tick();
        e_md_start = 1'b0; e_md_div = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("div_busy_%0d", k), 32'(md_busy), 32'd1);
            chk($sformatf("div_stall_%0d", k), 32'(stall), 32'd1);
            tick();
        end
        #1;
        chk("div_done_busy", 32'(md_busy), 32'd0);
        chk("div_done_stall", 32'(stall), 32'd0);

        // mult latency
        d_is_md = 1'b0; e_md_start = 1'b1; e_md_div = 1'b0;
        tick();
        e_md_start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("mult_last_busy", 32'(md_busy), 32'd1);
        tick();
        chk("mult_done_busy", 32'(md_busy), 32'd0);

        // flush coinciding with a stall leaves only a bubble in E
        idle(); tick();
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd7, 2'd2);
        tick();
        set_d(5'd0, 5'd7, 2'd0, 2'd0, 5'd9, 2'd1);
        flush = 1'b1;
        #1;
        chk("flush_stall", 32'(stall), 32'd1);
        tick();
        flush = 1'b0;
        set_d(5'd7, 5'd9, 2'd2, 2'd0, 5'd0, 2'd0);
        chk("flush_bubble_stall", 32'(stall), 32'd0);
        chk("flush_bubble_fwd", 32'(fwd_sel), 32'h0);

        // flush alone squashes the D writer
        idle(); tick(); tick(); tick();
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd8, 2'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_d(5'd0, 5'd8, 2'd0, 2'd0, 5'd0, 2'd0);
        chk("flush_only_stall", 32'(stall), 32'd0);

        // reset asserted mid-divide with a pending forward
        idle();
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd3, 2'd0);
        e_md_start = 1'b1; e_md_div = 1'b1;
        tick();
        e_md_start = 1'b0;
        set_d(5'd0, 5'd3, 2'd0, 2'd0, 5'd0, 2'd0);
        chk("pre_rst_fwd", 32'(fwd_sel), 32'h3);
        tick();
        d_is_md = 1'b1;
        #1;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(md_busy), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_fwd", 32'(fwd_sel), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_mflo_stall", 32'(stall), 32'd0);
        chk("post_rst_busy", 32'(md_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
